// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares the single physical-memory line port between the I-cache (reads
//   only) and the D-cache (reads and write-backs). One line transaction runs
//   at a time. The winner's address, write line and operation are latched at
//   grant and held for the whole burst. The completion is routed back to the
//   winner only.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : simultaneous requests alternate; the first tie after reset
//                 goes to the D-cache.
//     undefined : fixed priority; the D-cache always wins a tie.
//
// Ports
//   clk, rst                     clock; synchronous active-low reset
//   i_read, i_address            I-cache line read request and address
//   i_rdata, i_resp              line data and one-cycle completion to I-cache
//   d_read, d_write, d_address   D-cache line request and address
//   d_wdata                      D-cache write-back line
//   d_rdata, d_resp              line data and one-cycle completion to D-cache
//   pmem_read, pmem_write        strobes to the cacheline adaptor
//   pmem_address, pmem_wdata     latched address and write line
//   pmem_rdata, pmem_resp        adaptor read data and completion pulse
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_op_wr;      // 1 = write-back, 0 = read
  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic              r_rr_last_d;  // 1 = D-cache was granted last
`endif

  // The latches drive the port directly so the address/data never depend on
  // request inputs once a burst is underway.
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

  always_comb begin
    w_i_req     = i_read;
    w_d_req     = d_read | d_write;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_state_nxt = r_state;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_i_req && w_d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (r_rr_last_d) w_grant_i = 1'b1;
          else             w_grant_d = 1'b1;
`else
          w_grant_d = 1'b1;
`endif
        end else if (w_d_req) begin
          w_grant_d = 1'b1;
        end else if (w_i_req) begin
          w_grant_i = 1'b1;
        end
        if (w_grant_d)      w_state_nxt = ST_SERVE_D;
        else if (w_grant_i) w_state_nxt = ST_SERVE_I;
      end
      ST_SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp      = 1'b1;
          w_state_nxt = ST_RECOVER;
        end
      end
      ST_SERVE_D: begin
        pmem_read  = ~r_op_wr;
        pmem_write = r_op_wr;
        if (pmem_resp) begin
          d_resp      = 1'b1;
          w_state_nxt = ST_RECOVER;
        end
      end
      // One dead cycle lets the finished cache drop its request so it is not
      // granted a second time on a stale request.
      ST_RECOVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op_wr     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_last_d <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_addr  <= i_address;
        r_op_wr <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        r_rr_last_d <= 1'b0;
`endif
      end
      if (w_grant_d) begin
        r_addr  <= d_address;
        r_wdata <= d_wdata;
        r_op_wr <= d_write;
`ifdef ARB_ROUND_ROBIN_EN
        r_rr_last_d <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [LINE_W-1:0] PAT_A = {8{32'hA5A5_0001}};
  localparam logic [LINE_W-1:0] PAT_B = {8{32'h5A5A_0002}};
  localparam logic [LINE_W-1:0] PAT_C = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] PAT_W = {8{32'hDEAD_BEEF}};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd"},    pmem_read,  0);
    check({tag, "_wr"},    pmem_write, 0);
    check({tag, "_iresp"}, i_resp,     0);
    check({tag, "_dresp"}, d_resp,     0);
  endtask

  // Entered just after the granting edge. Holds the burst for n_cyc cycles,
  // pulses pmem_resp in the last one, drops the winner's request in RECOVER
  // and returns just after the edge back into IDLE.
  task automatic serve(input string tag, input bit exp_d, input bit exp_wr,
                       input logic [ADDR_W-1:0] exp_addr,
                       input logic [LINE_W-1:0] exp_wdata,
                       input int n_cyc, input logic [LINE_W-1:0] rdata);
    for (int k = 0; k < n_cyc; k++) begin
      check({tag, "_rd"},   pmem_read,  !exp_wr);
      check({tag, "_wr"},   pmem_write, exp_wr);
      check({tag, "_addr"}, pmem_address, exp_addr);
      if (exp_wr) check({tag, "_wdata"}, pmem_wdata, exp_wdata);
      if (k == n_cyc - 1) begin
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        #1;
        check({tag, "_iresp"}, i_resp, !exp_d);
        check({tag, "_dresp"}, d_resp, exp_d);
        if (exp_d) check({tag, "_drdata"}, d_rdata, rdata);
        else       check({tag, "_irdata"}, i_rdata, rdata);
      end else begin
        check({tag, "_iresp0"}, i_resp, 0);
        check({tag, "_dresp0"}, d_resp, 0);
      end
      tick();
    end
    pmem_resp = 1'b0;
    if (exp_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    #1;
    check_quiet({tag, "_recover"});
    tick();
    check_quiet({tag, "_idle"});
  endtask

  always @(negedge clk) begin
    if (rst && (pmem_read && pmem_write)) check("one_strobe", 1, 0);
  end

  initial begin
    // Reset
    tick();
    tick();
    check_quiet("reset");
    check("reset_addr",  pmem_address, 0);
    check("reset_wdata", pmem_wdata,   0);
    rst = 1'b1;
    tick();
    check_quiet("post_reset_idle");

    // First tie after reset: D wins in both builds, then I three cycles later
    i_read = 1'b1; i_address = 32'h0000_0100;
    d_read = 1'b1; d_address = 32'h0000_0200;
    tick();
    serve("tie1_d", 1, 0, 32'h0000_0200, '0, 1, PAT_C);
    check("tie1_gap_rd", pmem_read, 0);
    tick();
    serve("tie1_i", 0, 0, 32'h0000_0100, '0, 1, PAT_B);

    // Lone I read, adaptor answers after 4 strobe cycles
    i_read = 1'b1; i_address = 32'h0000_1000;
    tick();
    serve("iread", 0, 0, 32'h0000_1000, '0, 4, PAT_A);

    // Lone D write; d_wdata changes after grant must not reach pmem_wdata
    d_write = 1'b1; d_address = 32'h0000_2020; d_wdata = PAT_W;
    tick();
    d_wdata = ~PAT_W;
    d_address = 32'h0000_FFE0;
    serve("dwrite", 1, 1, 32'h0000_2020, PAT_W, 2, PAT_A);

    // Tie right after a D grant: round robin favours I, fixed priority D
    i_read = 1'b1; i_address = 32'h0000_6000;
    d_read = 1'b1; d_address = 32'h0000_7000;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    serve("tie2_i", 0, 0, 32'h0000_6000, '0, 1, PAT_B);
    tick();
    serve("tie2_d", 1, 0, 32'h0000_7000, '0, 1, PAT_C);
`else
    serve("tie2_d", 1, 0, 32'h0000_7000, '0, 1, PAT_C);
    tick();
    serve("tie2_i", 0, 0, 32'h0000_6000, '0, 1, PAT_B);
`endif

    // Reset in the middle of a D read; pending I read then served normally
    d_read = 1'b1; d_address = 32'h0000_3000;
    tick();
    check("rstmid_serve_rd", pmem_read, 1);
    i_read = 1'b1; i_address = 32'h0000_4000;
    rst = 1'b0;
    tick();
    d_read = 1'b0;
    check_quiet("rstmid_idle");
    check("rstmid_addr", pmem_address, 0);
    rst = 1'b1;
    tick();
    serve("rstmid_i", 0, 0, 32'h0000_4000, '0, 2, PAT_A);

    // Stray pmem_resp in IDLE
    pmem_resp = 1'b1;
    #1;
    check("stray_iresp", i_resp, 0);
    check("stray_dresp", d_resp, 0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check_quiet("stray_still_idle");
    tick();
    check_quiet("stray_idle2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
